mmio_timer: RTL and testbench

- Memory-mapped timer/counter peripheral; a responder on the processor's data-memory port (we / a / wd / rd), sitting beside dmem.
- The processor initiates loads and stores.
- This block decodes its own address window, answers reads combinationally in the same cycle (as dmem does), and commits writes on the clock edge.
- It provides a free-running or auto-reload counter with a compare match flag.

---
 rtl/mmio_timer_if.sv | 24 ++
 rtl/mmio_timer.sv | 165 ++++++++++++++++
 tb/tb_mmio_timer.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_timer_if.sv
// rtl/mmio_timer_if.sv - processor data-memory port bundle for the mmio_timer responder
interface mmio_timer_if;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        hit;

    modport master (
        output we,
        output a,
        output wd,
        input  rd,
        input  hit
    );

    modport slave (
        input  we,
        input  a,
        input  wd,
        output rd,
        output hit
    );
endinterface

// File: rtl/mmio_timer.sv
// rtl/mmio_timer.sv - memory-mapped prescaled timer with compare match (optional irq via TIMER_IRQ_EN)
module mmio_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0100,
    parameter int          PS_W      = 8
) (
    input  logic          clk,
    input  logic          reset,
    mmio_timer_if.slave   bus
`ifdef TIMER_IRQ_EN
    ,
    output logic          irq
`endif
);

    localparam logic [1:0] OFF_CTRL    = 2'd0;
    localparam logic [1:0] OFF_COUNT   = 2'd1;
    localparam logic [1:0] OFF_COMPARE = 2'd2;
    localparam logic [1:0] OFF_STATUS  = 2'd3;

    // Register state
    logic            ctrl_en;
    logic            ctrl_ar;
    logic            ctrl_ie;
    logic [PS_W-1:0] ctrl_ps;
    logic [31:0]     count;
    logic [31:0]     compare;
    logic            match;
    logic [PS_W-1:0] pcnt;

    // Decode
    logic       hit;
    logic [1:0] off;
    logic       wr;
    logic       wr_ctrl;
    logic       wr_count;
    logic       wr_compare;
    logic       wr_status;
    logic       tick;
    logic       at_compare;
    logic       match_set;
    logic       match_clr;

    assign hit        = (bus.a[31:4] == BASE_ADDR[31:4]);
    assign off        = bus.a[3:2];
    assign wr         = bus.we && hit;
    assign wr_ctrl    = wr && (off == OFF_CTRL);
    assign wr_count   = wr && (off == OFF_COUNT);
    assign wr_compare = wr && (off == OFF_COMPARE);
    assign wr_status  = wr && (off == OFF_STATUS);

    // A tick fires on the last cycle of each PS+1 cycle prescaler period.
    assign tick       = ctrl_en && (pcnt == ctrl_ps);
    assign at_compare = (count == compare);
    // A COUNT write in the same cycle suppresses match evaluation entirely.
    assign match_set  = tick && !wr_count && at_compare;
    assign match_clr  = wr_status && bus.wd[0];

    // Low address bits and unmapped data bits are architecturally ignored.
    logic unused_bits;
    assign unused_bits = ^{bus.a[1:0], bus.wd};

    // CTRL register; the irq-enable bit only exists when the irq output does.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_en <= 1'b0;
            ctrl_ar <= 1'b0;
            ctrl_ps <= '0;
        end else if (wr_ctrl) begin
            ctrl_en <= bus.wd[0];
            ctrl_ar <= bus.wd[1];
            ctrl_ps <= bus.wd[8 +: PS_W];
        end
    end

`ifdef TIMER_IRQ_EN
    // IRQ_ENA storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_ie <= 1'b0;
        end else if (wr_ctrl) begin
            ctrl_ie <= bus.wd[2];
        end
    end

    // irq is a registered copy of MATCH & IRQ_ENA, lagging by one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq <= 1'b0;
        end else begin
            irq <= match && ctrl_ie;
        end
    end
`else
    assign ctrl_ie = 1'b0;
`endif

    // Prescaler: held at zero while disabled, restarted by any CTRL write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcnt <= '0;
        end else if (wr_ctrl || !ctrl_en || tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

    // COUNT: software write has priority over a tick; auto-reload on match.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (wr_count) begin
            count <= bus.wd;
        end else if (tick) begin
            if (at_compare && ctrl_ar) begin
                count <= '0;
            end else begin
                count <= count + 32'd1;
            end
        end
    end

    // COMPARE: plain read/write; a same-cycle tick still sees the old value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            compare <= 32'hFFFF_FFFF;
        end else if (wr_compare) begin
            compare <= bus.wd;
        end
    end

    // MATCH: sticky; a new match beats a coincident write-1-to-clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            match <= 1'b0;
        end else if (match_set) begin
            match <= 1'b1;
        end else if (match_clr) begin
            match <= 1'b0;
        end
    end

    // Combinational read mux, zero outside the window.
    always_comb begin
        logic [31:0] ctrl_rd;
        ctrl_rd            = '0;
        ctrl_rd[0]         = ctrl_en;
        ctrl_rd[1]         = ctrl_ar;
        ctrl_rd[2]         = ctrl_ie;
        ctrl_rd[8 +: PS_W] = ctrl_ps;
        bus.rd             = '0;
        if (hit) begin
            case (off)
                OFF_CTRL:    bus.rd = ctrl_rd;
                OFF_COUNT:   bus.rd = count;
                OFF_COMPARE: bus.rd = compare;
                OFF_STATUS:  bus.rd = {31'd0, match};
                default:     bus.rd = '0;
            endcase
        end
    end

    assign bus.hit = hit;

endmodule

// File: tb/tb_mmio_timer.sv
// tb/tb_mmio_timer.sv - randomized scoreboard bench for mmio_timer against a behavioural model
module tb_mmio_timer;

    localparam logic [31:0] BASE = 32'h0000_0100;
    localparam int          PS_W = 8;

    logic clk = 1'b0;
    logic reset;
`ifdef TIMER_IRQ_EN
    logic irq;
`endif

    mmio_timer_if bus ();

    mmio_timer #(.BASE_ADDR(BASE), .PS_W(PS_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
`ifdef TIMER_IRQ_EN
        ,
        .irq   (irq)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] rd;
        logic        hit;
    } exp_t;

    exp_t exp_q[$];
    bit   check_req = 1'b0;
    int   checks    = 0;
    int   failures  = 0;

    // Reference model: architectural registers plus cycles elapsed since the prescaler phase started
    logic        m_en, m_ar, m_ie;
    int          m_ps;
    logic [31:0] m_count, m_compare;
    logic        m_match, m_irq;
    int          m_elapsed;

    function automatic void model_reset();
        m_en = 0; m_ar = 0; m_ie = 0; m_ps = 0;
        m_count = 0; m_compare = 32'hFFFF_FFFF;
        m_match = 0; m_irq = 0; m_elapsed = 0;
    endfunction

    function automatic logic model_hit(input logic [31:0] addr);
        return addr[31:4] == BASE[31:4];
    endfunction

    function automatic logic [31:0] model_rd(input logic [31:0] addr);
        logic [31:0] v;
        v = 0;
        if (!model_hit(addr)) return 0;
        case (addr[3:2])
            2'd0: begin
                v[0] = m_en; v[1] = m_ar; v[2] = m_ie;
                v[8 +: PS_W] = m_ps[PS_W-1:0];
            end
            2'd1: v = m_count;
            2'd2: v = m_compare;
            default: v = {31'd0, m_match};
        endcase
        return v;
    endfunction

    function automatic void model_step(input logic w, input logic [31:0] addr, input logic [31:0] data);
        bit   h, wc, wn, wp, ws, tk;
        logic [31:0] n_count;
        logic n_match;
        h  = model_hit(addr) && w;
        wc = h && addr[3:2] == 2'd0;
        wn = h && addr[3:2] == 2'd1;
        wp = h && addr[3:2] == 2'd2;
        ws = h && addr[3:2] == 2'd3;
        tk = m_en && ((m_elapsed % (m_ps + 1)) == m_ps);
        n_count = m_count;
        n_match = m_match;
        if (ws && data[0]) n_match = 0;
        if (wn) n_count = data;
        else if (tk) begin
            if (m_count == m_compare) begin
                n_match = 1;
                n_count = m_ar ? 32'd0 : m_count + 32'd1;
            end else begin
                n_count = m_count + 32'd1;
            end
        end
`ifdef TIMER_IRQ_EN
        m_irq = m_match && m_ie;
`endif
        if (wc) m_elapsed = 0;
        else if (m_en) m_elapsed = m_elapsed + 1;
        else m_elapsed = 0;
        if (wp) m_compare = data;
        if (wc) begin
            m_en = data[0];
            m_ar = data[1];
`ifdef TIMER_IRQ_EN
            m_ie = data[2];
`endif
            m_ps = int'(data[8 +: PS_W]);
        end
        m_count = n_count;
        m_match = n_match;
    endfunction

    // One bus cycle; when chk is set the expected read is queued for the monitor
    task automatic do_cycle(input logic w, input logic [31:0] addr, input logic [31:0] data,
                            input bit chk, input string nm, input bit use_const, input logic [31:0] cexp);
        exp_t e;
        bus.we = w; bus.a = addr; bus.wd = data;
        check_req = chk;
        if (chk) begin
            e.name = nm;
            e.rd   = use_const ? cexp : model_rd(addr);
            e.hit  = model_hit(addr);
            exp_q.push_back(e);
        end
        @(posedge clk);
        if (reset) model_reset();
        else model_step(w, addr, data);
        #1;
        check_req = 1'b0;
    endtask

    task automatic wr(input logic [3:0] off, input logic [31:0] data);
        do_cycle(1'b1, BASE | 32'(off), data, 1'b0, "", 1'b0, 32'd0);
    endtask

    task automatic rd_model(input logic [3:0] off, input string nm);
        do_cycle(1'b0, BASE | 32'(off), 32'd0, 1'b1, nm, 1'b0, 32'd0);
    endtask

    task automatic rd_const(input logic [3:0] off, input string nm, input logic [31:0] v);
        do_cycle(1'b0, BASE | 32'(off), 32'd0, 1'b1, nm, 1'b1, v);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(1'b0, 32'h0, 32'h0, 1'b0, "", 1'b0, 32'd0);
    endtask

    // Monitor: compare every presented read against the head of the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (check_req) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_empty a=%h rd=%h", bus.a, bus.rd);
            end else begin
                e = exp_q.pop_front();
                if (bus.rd !== e.rd || bus.hit !== e.hit) begin
                    failures++;
                    $display("FAIL %s a=%h rd=%h hit=%b required rd=%h hit=%b",
                             e.name, bus.a, bus.rd, bus.hit, e.rd, e.hit);
                end
            end
        end
`ifdef TIMER_IRQ_EN
        if (!reset) begin
            checks++;
            if (irq !== m_irq) begin
                failures++;
                $display("FAIL irq got=%b required=%b", irq, m_irq);
            end
        end
`endif
    end

    initial begin
        logic [31:0] addr, data;
        int op;
        reset = 1'b1;
        bus.we = 0; bus.a = 0; bus.wd = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset values
        rd_const(4'h0, "reset_ctrl", 32'h0);
        rd_const(4'h4, "reset_count", 32'h0);
        rd_const(4'h8, "reset_compare", 32'hFFFF_FFFF);
        rd_const(4'hC, "reset_status", 32'h0);
        do_cycle(1'b0, 32'h0000_0200, 32'h0, 1'b1, "reset_nohit", 1'b1, 32'h0);

        // Auto-reload with PS=0
        wr(4'h8, 32'd3);
        wr(4'h0, 32'h3);
        rd_const(4'h4, "ar_c0", 32'd0);
        rd_const(4'h4, "ar_c1", 32'd1);
        rd_const(4'h4, "ar_c2", 32'd2);
        rd_const(4'h4, "ar_c3", 32'd3);
        rd_const(4'h4, "ar_c4", 32'd0);
        rd_const(4'h4, "ar_c5", 32'd1);
        rd_const(4'hC, "ar_match", 32'd1);
        wr(4'h0, 32'h0);
        wr(4'hC, 32'h1);
        rd_const(4'hC, "ar_clear", 32'd0);

        // Prescaler PS=2, no reload
        wr(4'h4, 32'd0);
        wr(4'h8, 32'hFFFF_FFFF);
        wr(4'h0, 32'h0000_0201);
        idle(30);
        rd_const(4'h4, "ps_count30", 32'd10);
        wr(4'h0, 32'h0000_0201);
        for (int i = 0; i < 7; i++) rd_model(4'h4, "ps_rephase");

        // Wrap through zero
        wr(4'h0, 32'h0);
        wr(4'h4, 32'hFFFF_FFFE);
        wr(4'h8, 32'd5);
        wr(4'h0, 32'h1);
        rd_const(4'h4, "wrap_ffff", 32'hFFFF_FFFE);
        rd_const(4'h4, "wrap_ffff2", 32'hFFFF_FFFF);
        rd_const(4'h4, "wrap_zero", 32'd0);
        for (int i = 0; i < 8; i++) begin
            rd_model(4'hC, "wrap_status");
        end

        // Collision: COUNT write beats tick
        wr(4'h4, 32'd100);
        rd_const(4'h4, "coll_count", 32'd100);

        // Collision: match set beats status clear
        wr(4'h0, 32'h0);
        wr(4'hC, 32'h1);
        wr(4'h8, 32'd10);
        wr(4'h4, 32'd10);
        wr(4'h0, 32'h1);
        wr(4'hC, 32'h1);
        rd_const(4'hC, "coll_status", 32'd1);

        // IRQ scenario; CTRL readback depends on build
        wr(4'h0, 32'h0);
        wr(4'hC, 32'h1);
        wr(4'h4, 32'd0);
        wr(4'h8, 32'd2);
        wr(4'h0, 32'h7);
        for (int i = 0; i < 5; i++) rd_model(4'hC, "irq_status");
        wr(4'h0, 32'h3);
        rd_model(4'h0, "irq_ctrl");
        idle(3);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            op = int'($urandom_range(0, 7));
            case (op)
                0, 1: rd_model({$urandom_range(0, 3), 2'($urandom)}, "rand_read");
                2: begin
                    data = $urandom;
                    data[15:8] = 8'($urandom_range(0, 3));
                    wr(4'h0, data);
                end
                3: wr(4'h4, m_compare - 32'($urandom_range(0, 6)));
                4: wr(4'h8, ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 12)));
                5: wr(4'hC, $urandom);
                6: begin
                    addr = $urandom;
                    if (addr[31:4] == BASE[31:4]) addr[31] = ~addr[31];
                    do_cycle(1'($urandom), addr, $urandom, 1'b1, "rand_nohit", 1'b0, 32'd0);
                end
                default: idle(int'($urandom_range(1, 4)));
            endcase
        end

        // Asynchronous reset mid-count, mid-cycle
        wr(4'h8, 32'hFFFF_FFFF);
        wr(4'h0, 32'h1);
        idle(5);
        #2 reset = 1'b1;
        model_reset();
        rd_const(4'h0, "async_ctrl", 32'h0);
        rd_const(4'h4, "async_count", 32'h0);
        rd_const(4'h8, "async_compare", 32'hFFFF_FFFF);
        rd_const(4'hC, "async_status", 32'h0);
        do_cycle(1'b0, 32'h0000_0200, 32'h0, 1'b1, "async_nohit", 1'b1, 32'h0);
        reset = 1'b0;
        idle(2);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain left=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
